// File: rtl/tap_pkg.sv
// Shared definitions for the tap-tempo period controller: FSM state encodings and
// default timing constants. The time-pulse strobe period is PULSE_PER_NS nanoseconds.
package tap_pkg;

   typedef enum logic [0:0] {
      S_IDLE    = 1'b0,
      S_MEASURE = 1'b1
   } tap_state_e;

   localparam int unsigned PULSE_PER_NS        = 5120;
   // 2 s of pulses without a tap (30 BPM floor)
   localparam int unsigned DEF_TIMEOUT_PULSES  = 390625;
   // 0.24 s shortest accepted period (250 BPM ceiling)
   localparam int unsigned DEF_MIN_PULSES      = 46875;
   localparam int unsigned DEF_NB_SAMPLES_LOG2 = 2;
   localparam int unsigned DEF_PERIOD_W        = 19;

endpackage

// File: rtl/tap_avg.sv
// Period averaging plus result register with valid/ready handoff.
// Build option SLIDING_AVG_EN: when defined, a moving average over the last
// 2^NB_SAMPLES_LOG2 periods is produced on every accepted tap once the history has
// filled; when undefined, one block average is produced per 2^NB_SAMPLES_LOG2 periods.
module tap_avg
   import tap_pkg::*;
#(
   parameter int unsigned NB_SAMPLES_LOG2 = DEF_NB_SAMPLES_LOG2,
   parameter int unsigned PERIOD_W        = DEF_PERIOD_W
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                sample_vld_i,
   input  logic [PERIOD_W-1:0] sample_i,
   input  logic                clear_i,
   output logic [PERIOD_W-1:0] period_o,
   output logic                period_valid_o,
   input  logic                period_ready_i
);

   localparam int unsigned NUM   = 1 << NB_SAMPLES_LOG2;
   localparam int unsigned ACC_W = PERIOD_W + NB_SAMPLES_LOG2;

   logic                load;
   logic [PERIOD_W-1:0] result;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic                valid_q, valid_d;

`ifdef SLIDING_AVG_EN
   localparam int unsigned FILL_W = NB_SAMPLES_LOG2 + 1;
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(NUM);
   localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(NUM - 1);

   logic [PERIOD_W-1:0] hist_q [NUM];
   logic [PERIOD_W-1:0] hist_d [NUM];
   logic [ACC_W-1:0]    sum_q, sum_d, sum_new;
   logic [FILL_W-1:0]   fill_q, fill_d;

   // Running sum: add the newest period, drop the oldest (zero until history fills).
   always_comb begin
      sum_new = sum_q + ACC_W'(sample_i) - ACC_W'(hist_q[NUM-1]);
      result  = PERIOD_W'(sum_new >> NB_SAMPLES_LOG2);
      sum_d   = sum_q;
      fill_d  = fill_q;
      load    = 1'b0;
      for (int i = 0; i < NUM; i++) begin
         hist_d[i] = hist_q[i];
      end
      if (clear_i) begin
         sum_d  = '0;
         fill_d = '0;
         for (int i = 0; i < NUM; i++) begin
            hist_d[i] = '0;
         end
      end else if (sample_vld_i) begin
         sum_d     = sum_new;
         hist_d[0] = sample_i;
         for (int i = 1; i < NUM; i++) begin
            hist_d[i] = hist_q[i-1];
         end
         load = (fill_q >= FILL_LAST);
         if (fill_q != FILL_FULL) begin
            fill_d = fill_q + FILL_W'(1);
         end
      end
   end

   // History, running sum and fill count.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sum_q  <= '0;
         fill_q <= '0;
         for (int i = 0; i < NUM; i++) begin
            hist_q[i] <= '0;
         end
      end else begin
         sum_q  <= sum_d;
         fill_q <= fill_d;
         for (int i = 0; i < NUM; i++) begin
            hist_q[i] <= hist_d[i];
         end
      end
   end
`else
   localparam int unsigned CNT_W = (NB_SAMPLES_LOG2 > 0) ? NB_SAMPLES_LOG2 : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM - 1);

   logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
   logic [CNT_W-1:0] scnt_q, scnt_d;

   // Block accumulate; the sample that wraps the count completes the average.
   always_comb begin
      acc_sum = acc_q + ACC_W'(sample_i);
      result  = PERIOD_W'(acc_sum >> NB_SAMPLES_LOG2);
      acc_d   = acc_q;
      scnt_d  = scnt_q;
      load    = 1'b0;
      if (clear_i) begin
         acc_d  = '0;
         scnt_d = '0;
      end else if (sample_vld_i) begin
         if (scnt_q == CNT_LAST) begin
            load   = 1'b1;
            acc_d  = '0;
            scnt_d = '0;
         end else begin
            acc_d  = acc_sum;
            scnt_d = scnt_q + CNT_W'(1);
         end
      end
   end

   // Accumulator and sample count.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         acc_q  <= '0;
         scnt_q <= '0;
      end else begin
         acc_q  <= acc_d;
         scnt_q <= scnt_d;
      end
   end
`endif

   // Newest result wins; a load in the acceptance cycle keeps valid asserted.
   always_comb begin
      period_d = load ? result : period_q;
      valid_d  = load | (valid_q & ~period_ready_i);
   end

   // Output result and valid register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         period_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         period_q <= period_d;
         valid_q  <= valid_d;
      end
   end

   assign period_o       = period_q;
   assign period_valid_o = valid_q;

endmodule

// File: rtl/tap_period_ctrl.sv
// Tap-tempo period measurement: tap edge detection, time-pulse period counter,
// too-fast tap rejection and timeout abort, feeding the tap_avg averaging stage.
// Build option SLIDING_AVG_EN selects moving instead of block averaging in tap_avg.
module tap_period_ctrl
   import tap_pkg::*;
#(
   parameter int unsigned TIMEOUT_PULSES  = DEF_TIMEOUT_PULSES,
   parameter int unsigned MIN_PULSES      = DEF_MIN_PULSES,
   parameter int unsigned NB_SAMPLES_LOG2 = DEF_NB_SAMPLES_LOG2,
   parameter int unsigned PERIOD_W        = DEF_PERIOD_W
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                tp_i,
   input  logic                btn_i,
   output logic [PERIOD_W-1:0] period_o,
   output logic                period_valid_o,
   input  logic                period_ready_i,
   output logic                busy_o,
   output logic                timeout_o
);

   localparam logic [PERIOD_W-1:0] MIN_CNT = PERIOD_W'(MIN_PULSES);
   localparam logic [PERIOD_W-1:0] TO_LAST = PERIOD_W'(TIMEOUT_PULSES - 1);
   localparam logic [PERIOD_W-1:0] ONE     = PERIOD_W'(1);

   tap_state_e          state_q, state_d;
   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic                btn_q;
   logic                timeout_q, timeout_d;
   logic                rise;
   logic                sample_vld;
   logic                clear;

   assign rise = btn_i & ~btn_q;

   // Next state: accepted tap beats timeout; a too-fast tap only lets counting go on.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      timeout_d  = 1'b0;
      sample_vld = 1'b0;
      clear      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (rise) begin
               state_d = S_MEASURE;
            end
         end
         S_MEASURE: begin
            if (rise && (cnt_q >= MIN_CNT)) begin
               sample_vld = 1'b1;
               // The strobe in the tap cycle already belongs to the next period.
               cnt_d      = tp_i ? ONE : '0;
            end else if (tp_i && (cnt_q == TO_LAST)) begin
               state_d   = S_IDLE;
               cnt_d     = '0;
               timeout_d = 1'b1;
               clear     = 1'b1;
            end else if (tp_i) begin
               cnt_d = cnt_q + ONE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State, period counter, button history and timeout pulse.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         btn_q     <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         btn_q     <= btn_i;
         timeout_q <= timeout_d;
      end
   end

   assign busy_o    = (state_q == S_MEASURE);
   assign timeout_o = timeout_q;

   tap_avg #(
      .NB_SAMPLES_LOG2 (NB_SAMPLES_LOG2),
      .PERIOD_W        (PERIOD_W)
   ) u_avg (
      .clk_i          (clk_i),
      .rst_n_i        (rst_n_i),
      .sample_vld_i   (sample_vld),
      .sample_i       (cnt_q),
      .clear_i        (clear),
      .period_o       (period_o),
      .period_valid_o (period_valid_o),
      .period_ready_i (period_ready_i)
   );

endmodule

// File: tb/tb_tap_period_ctrl.sv
// Directed bench for tap_period_ctrl with short timing constants
// (TIMEOUT_PULSES=64, MIN_PULSES=4, 4 periods averaged, tp every 4 clocks).
module tb_tap_period_ctrl;

   localparam int unsigned PW = 19;

   logic          clk_i = 1'b0;
   logic          rst_n_i;
   logic          tp_i;
   logic          btn_i;
   logic [PW-1:0] period_o;
   logic          period_valid_o;
   logic          period_ready_i;
   logic          busy_o;
   logic          timeout_o;

   int            n_vec = 0;
   int            n_bad = 0;
   int            hs_cnt;
   int            valid_cyc;
   int            to_cnt;
   logic [PW-1:0] hs_last;

   always #5 clk_i = ~clk_i;

   tap_period_ctrl #(
      .TIMEOUT_PULSES  (64),
      .MIN_PULSES      (4),
      .NB_SAMPLES_LOG2 (2),
      .PERIOD_W        (PW)
   ) dut (
      .clk_i          (clk_i),
      .rst_n_i        (rst_n_i),
      .tp_i           (tp_i),
      .btn_i          (btn_i),
      .period_o       (period_o),
      .period_valid_o (period_valid_o),
      .period_ready_i (period_ready_i),
      .busy_o         (busy_o),
      .timeout_o      (timeout_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock: apply inputs at the falling edge, observe after the next falling edge.
   task automatic step(input logic tp, input logic btn);
      tp_i  = tp;
      btn_i = btn;
      if (period_valid_o && period_ready_i) begin
         hs_cnt++;
         hs_last = period_o;
      end
      @(negedge clk_i);
      if (period_valid_o) valid_cyc++;
      if (timeout_o) to_cnt++;
   endtask

   task automatic pulse(input int n);
      for (int i = 0; i < n; i++) begin
         step(1'b0, 1'b0);
         step(1'b0, 1'b0);
         step(1'b0, 1'b0);
         step(1'b1, 1'b0);
      end
   endtask

   task automatic tap();
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
   endtask

   task automatic clr_mon();
      hs_cnt    = 0;
      valid_cyc = 0;
      to_cnt    = 0;
      hs_last   = '0;
   endtask

   initial begin
      rst_n_i        = 1'b0;
      tp_i           = 1'b0;
      btn_i          = 1'b0;
      period_ready_i = 1'b1;
      clr_mon();
      @(negedge clk_i);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      chk("reset_period", 32'(period_o), 0);
      chk("reset_valid", 32'(period_valid_o), 0);
      chk("reset_busy", 32'(busy_o), 0);
      chk("reset_timeout", 32'(timeout_o), 0);
      rst_n_i = 1'b1;
      step(1'b0, 1'b0);

`ifndef SLIDING_AVG_EN
      // 1: five taps 10 tp apart
      clr_mon();
      tap();
      chk("t1_busy", 32'(busy_o), 1);
      for (int i = 0; i < 4; i++) begin
         pulse(10);
         tap();
      end
      chk("t1_hs_cnt", hs_cnt, 1);
      chk("t1_hs_period", 32'(hs_last), 10);
      chk("t1_valid_cycles", valid_cyc, 1);
      chk("t1_period_hold", 32'(period_o), 10);
      chk("t1_valid_low", 32'(period_valid_o), 0);

      // 2: periods 10,11,12,14 with a too-fast tap inside the 12
      clr_mon();
      pulse(10); tap();
      pulse(11); tap();
      pulse(2);  tap();
      pulse(10); tap();
      pulse(14); tap();
      chk("t2_hs_cnt", hs_cnt, 1);
      chk("t2_period", 32'(hs_last), 11);

      // 3: partial block, then timeout, then restart
      pulse(10); tap();
      clr_mon();
      pulse(63);
      chk("t3_busy_before", 32'(busy_o), 1);
      chk("t3_no_early_to", to_cnt, 0);
      pulse(1);
      chk("t3_timeout_hi", 32'(timeout_o), 1);
      chk("t3_busy_after", 32'(busy_o), 0);
      step(1'b0, 1'b0);
      chk("t3_timeout_lo", 32'(timeout_o), 0);
      chk("t3_to_cnt", to_cnt, 1);
      chk("t3_no_result", hs_cnt, 0);
      tap();
      chk("t3_restart_busy", 32'(busy_o), 1);
      for (int i = 0; i < 4; i++) begin
         pulse(10);
         tap();
      end
      chk("t3_restart_hs", hs_cnt, 1);
      chk("t3_restart_period", 32'(hs_last), 10);

      // 4: consumer stalled across two results
      period_ready_i = 1'b0;
      clr_mon();
      for (int i = 0; i < 4; i++) begin
         pulse(10);
         tap();
      end
      chk("t4_valid_first", 32'(period_valid_o), 1);
      chk("t4_period_first", 32'(period_o), 10);
      for (int i = 0; i < 4; i++) begin
         pulse(20);
         tap();
      end
      chk("t4_valid_second", 32'(period_valid_o), 1);
      chk("t4_period_second", 32'(period_o), 20);
      chk("t4_no_hs", hs_cnt, 0);
      period_ready_i = 1'b1;
      chk("t4_valid_held", 32'(period_valid_o), 1);
      step(1'b0, 1'b0);
      chk("t4_valid_drop", 32'(period_valid_o), 0);
      chk("t4_hs_cnt", hs_cnt, 1);
      chk("t4_hs_period", 32'(hs_last), 20);

      // 5: tap coincident with tp at counter 63; then reset mid-measurement
      clr_mon();
      pulse(63);
      step(1'b1, 1'b1);
      step(1'b0, 1'b0);
      chk("t5_no_timeout", to_cnt, 0);
      chk("t5_busy", 32'(busy_o), 1);
      pulse(9);  tap();
      pulse(11); tap();
      period_ready_i = 1'b0;
      pulse(11); tap();
      chk("t5_valid", 32'(period_valid_o), 1);
      chk("t5_period", 32'(period_o), 23);
      pulse(5); tap();
      pulse(3);
      #1 rst_n_i = 1'b0;
      #1;
      chk("t5_rst_period", 32'(period_o), 0);
      chk("t5_rst_valid", 32'(period_valid_o), 0);
      chk("t5_rst_busy", 32'(busy_o), 0);
      chk("t5_rst_timeout", 32'(timeout_o), 0);
      @(negedge clk_i);
      rst_n_i        = 1'b1;
      period_ready_i = 1'b1;
      step(1'b0, 1'b0);
      chk("t5_post_rst_busy", 32'(busy_o), 0);
`endif

      // 6: periods 8,8,8,8 then 16
      clr_mon();
      tap();
      for (int i = 0; i < 4; i++) begin
         pulse(8);
         tap();
      end
      chk("t6_first_hs", hs_cnt, 1);
      chk("t6_first_period", 32'(hs_last), 8);
      pulse(16);
      tap();
`ifdef SLIDING_AVG_EN
      chk("t6_slide_hs", hs_cnt, 2);
      chk("t6_slide_period", 32'(hs_last), 10);
`else
      chk("t6_block_hs", hs_cnt, 1);
      chk("t6_block_valid", 32'(period_valid_o), 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
